// File: rtl/scope_pkg.sv
// Shared definitions for the sample-capture path: state encoding and
// default widths used by the ADC interface, capture and display blocks.
package scope_pkg;

    localparam int SCOPE_DATA_W = 14;
    localparam int SCOPE_AW     = 9;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        PREFILL   = 3'd1,
        WAIT_TRIG = 3'd2,
        POSTFILL  = 3'd3,
        DONE      = 3'd4
    } state_t;

endpackage

// File: rtl/scope_dpram.sv
// Simple dual-port sample RAM: one write port, one registered read port.
module scope_dpram
    import scope_pkg::*;
#(
    parameter int DATA_W = SCOPE_DATA_W,
    parameter int AW     = SCOPE_AW
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [AW-1:0]     waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [AW-1:0]     raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [2**AW];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    // Output register carries a sync reset; the array itself is never reset.
    always_ff @(posedge clk) begin
        if (!rst) rdata <= '0;
        else      rdata <= mem[raddr];
    end

endmodule

// File: rtl/scope_capture.sv
// Circular sample capture with level/slope or forced trigger and a
// programmable pre-trigger window, read back in trigger-relative order.
module scope_capture
    import scope_pkg::*;
#(
    parameter int DATA_W = SCOPE_DATA_W,
    parameter int AW     = SCOPE_AW
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] sample_in,
    input  logic              sample_valid,
    input  logic              arm,
    input  logic              force_trig,
    input  logic [DATA_W-1:0] trig_level,
    input  logic              trig_slope,
    input  logic [AW-1:0]     pre_count,
    input  logic [AW-1:0]     rd_addr,
    output logic [DATA_W-1:0] rd_data,
    output logic [2:0]        state_o,
    output logic              capture_done,
    output logic              trig_forced
);

    state_t state, state_d;

    logic [AW-1:0]            wr_ptr, start_ptr, cnt, cfg_pre, rd_phys;
    logic signed [DATA_W-1:0] cfg_level, prev, curr;
    logic                     cfg_slope, prev_valid, force_pend;
    logic                     capturing, wr_en, level_hit, trig_fire;

    assign curr      = $signed(sample_in);
    assign capturing = (state == PREFILL) || (state == WAIT_TRIG) ||
                       (state == POSTFILL);
    assign wr_en     = rst && sample_valid && !arm && capturing;
    assign trig_fire = wr_en && (state == WAIT_TRIG) &&
                       (level_hit || force_pend);
    assign rd_phys   = start_ptr + rd_addr;
    assign state_o   = state;

    always_comb begin
        level_hit = 1'b0;
        if (prev_valid) begin
            if (cfg_slope) level_hit = (prev < cfg_level) && (curr >= cfg_level);
            else           level_hit = (prev > cfg_level) && (curr <= cfg_level);
        end
    end

    always_comb begin
        state_d = state;
        if (arm) begin
            if (pre_count == '0) state_d = WAIT_TRIG;
            else                 state_d = PREFILL;
        end else if (wr_en) begin
            unique case (state)
                PREFILL:   if (cnt + 1'b1 == cfg_pre) state_d = WAIT_TRIG;
                WAIT_TRIG: begin
                    if (trig_fire) begin
                        if (cfg_pre == '1) state_d = DONE;
                        else               state_d = POSTFILL;
                    end
                end
                POSTFILL:  if (cnt == AW'(1)) state_d = DONE;
                default:   ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) state <= IDLE;
        else      state <= state_d;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr       <= '0;
            start_ptr    <= '0;
            cnt          <= '0;
            cfg_pre      <= '0;
            cfg_level    <= '0;
            cfg_slope    <= 1'b0;
            prev         <= '0;
            prev_valid   <= 1'b0;
            force_pend   <= 1'b0;
            capture_done <= 1'b0;
            trig_forced  <= 1'b0;
        end else if (arm) begin
            cfg_pre      <= pre_count;
            cfg_level    <= $signed(trig_level);
            cfg_slope    <= trig_slope;
            cnt          <= '0;
            prev_valid   <= 1'b0;
            force_pend   <= 1'b0;
            capture_done <= 1'b0;
            trig_forced  <= 1'b0;
        end else begin
            if (state == WAIT_TRIG && force_trig) force_pend <= 1'b1;
            if (wr_en) begin
                wr_ptr     <= wr_ptr + 1'b1;
                prev       <= curr;
                prev_valid <= 1'b1;
                unique case (state)
                    PREFILL:   cnt <= cnt + 1'b1;
                    WAIT_TRIG: begin
                        if (trig_fire) begin
                            // Window ends DEPTH-1-pre samples after trigger.
                            start_ptr    <= wr_ptr - cfg_pre;
                            cnt          <= ~cfg_pre;
                            trig_forced  <= !level_hit;
                            force_pend   <= 1'b0;
                            capture_done <= (cfg_pre == '1);
                        end
                    end
                    POSTFILL:  begin
                        cnt <= cnt - 1'b1;
                        if (cnt == AW'(1)) capture_done <= 1'b1;
                    end
                    default:   ;
                endcase
            end
        end
    end

    scope_dpram #(
        .DATA_W (DATA_W),
        .AW     (AW)
    ) u_ram (
        .clk   (clk),
        .rst   (rst),
        .we    (wr_en),
        .waddr (wr_ptr),
        .wdata (sample_in),
        .raddr (rd_phys),
        .rdata (rd_data)
    );

endmodule

// File: tb/tb_scope_capture.sv
// Self-checking bench for scope_capture: scoreboard of expected readback.
module tb_scope_capture;
    import scope_pkg::*;

    localparam int DW    = SCOPE_DATA_W;
    localparam int AW    = SCOPE_AW;
    localparam int DEPTH = 1 << AW;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          sample_valid = 1'b0;
    logic          arm = 1'b0;
    logic          force_trig = 1'b0;
    logic          trig_slope = 1'b0;
    logic [DW-1:0] sample_in = '0;
    logic [DW-1:0] trig_level = '0;
    logic [AW-1:0] pre_count = '0;
    logic [AW-1:0] rd_addr = '0;
    logic [DW-1:0] rd_data;
    logic [2:0]    state_o;
    logic          capture_done;
    logic          trig_forced;

    int n_cmp = 0;
    int n_err = 0;
    int hist[$];
    int exp_q[$];
    int n;

    always #5 clk = ~clk;

    scope_capture dut (
        .clk          (clk),
        .rst          (rst),
        .sample_in    (sample_in),
        .sample_valid (sample_valid),
        .arm          (arm),
        .force_trig   (force_trig),
        .trig_level   (trig_level),
        .trig_slope   (trig_slope),
        .pre_count    (pre_count),
        .rd_addr      (rd_addr),
        .rd_data      (rd_data),
        .state_o      (state_o),
        .capture_done (capture_done),
        .trig_forced  (trig_forced)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input int got, input int exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic send(input int v);
        sample_in    = DW'(v);
        sample_valid = 1'b1;
        hist.push_back(v);
        tick();
        sample_valid = 1'b0;
        repeat (3) tick();
    endtask

    // Inputs are scrambled after the arm cycle so only latched config counts.
    task automatic arm_cfg(input int lvl, input logic slope, input int pre);
        trig_level = DW'(lvl);
        trig_slope = slope;
        pre_count  = AW'(pre);
        arm        = 1'b1;
        tick();
        arm        = 1'b0;
        trig_level = DW'(-lvl - 1);
        trig_slope = ~slope;
        pre_count  = ~pre_count;
        hist.delete();
    endtask

    function automatic int gen(input int mode, input int base, input int k);
        if (mode == 0)      return base + k;
        else if (mode == 1) return ((k / 54) % 2 == 0) ? 2000 : -2000;
        else                return 5;
    endfunction

    task automatic run_done(input int mode, input int base, input int limit,
                            output int cnt);
        cnt = 0;
        while (!capture_done && cnt < limit) begin
            send(gen(mode, base, cnt));
            cnt++;
        end
        if (!capture_done) check("done_timeout", 0, 1);
    endtask

    task automatic rd(input string tag, input int a, input int e);
        rd_addr = AW'(a);
        exp_q.push_back(e);
        tick();
        check(tag, int'($signed(rd_data)), exp_q.pop_front());
    endtask

    task automatic rd_window(input string tag);
        if (hist.size() < DEPTH) begin
            check({tag, "_hist"}, hist.size(), DEPTH);
        end else begin
            for (int i = 0; i < DEPTH; i++)
                rd(tag, i, hist[hist.size() - DEPTH + i]);
        end
    endtask

    initial begin
        // Reset with samples toggling
        for (int i = 0; i < 3; i++) begin
            sample_valid = ~sample_valid;
            sample_in    = DW'(123);
            tick();
        end
        sample_valid = 1'b0;
        check("rst_state", int'(state_o), 0);
        check("rst_done", int'(capture_done), 0);
        check("rst_forced", int'(trig_forced), 0);
        check("rst_rd", int'($signed(rd_data)), 0);
        rst = 1'b1;
        tick();

        // Rising ramp, pre 100
        arm_cfg(0, 1'b1, 100);
        check("ramp_arm_state", int'(state_o), 1);
        run_done(0, -300, 2000, n);
        check("ramp_nsamp", n, 712);
        check("ramp_state", int'(state_o), 4);
        check("ramp_forced", int'(trig_forced), 0);
        rd("ramp_r0", 0, -100);
        rd("ramp_r100", 100, 0);
        rd("ramp_r511", 511, 411);
        rd_window("ramp_win");

        // Falling square wave, pre 10
        arm_cfg(1000, 1'b0, 10);
        check("sq_arm_state", int'(state_o), 1);
        check("sq_arm_done", int'(capture_done), 0);
        run_done(1, 0, 2000, n);
        check("sq_nsamp", n, 556);
        rd("sq_r10", 10, -2000);
        rd("sq_r9", 9, 2000);
        check("sq_forced", int'(trig_forced), 0);

        // Forced trigger, pre 0
        arm_cfg(8191, 1'b1, 0);
        check("frc_arm_state", int'(state_o), 2);
        repeat (2000) send(5);
        check("frc_wait_state", int'(state_o), 2);
        check("frc_wait_done", int'(capture_done), 0);
        force_trig = 1'b1;
        tick();
        force_trig = 1'b0;
        run_done(2, 0, 1000, n);
        check("frc_nsamp", n, 512);
        check("frc_forced", int'(trig_forced), 1);
        rd_window("frc_win");

        // pre 511: done on the trigger sample itself
        arm_cfg(0, 1'b1, 511);
        run_done(0, -600, 2000, n);
        check("p511_nsamp", n, 601);
        check("p511_state", int'(state_o), 4);
        rd("p511_r511", 511, 0);
        rd("p511_r0", 0, -511);

        // No trigger on flat or non-crossing input
        arm_cfg(0, 1'b1, 0);
        send(0);
        send(0);
        send(0);
        send(1);
        check("flat_state", int'(state_o), 2);
        send(-1);
        send(0);
        check("cross_state", int'(state_o), 3);

        // Re-arm in POSTFILL with a concurrent sample that must be dropped
        send(0);
        sample_in    = DW'(777);
        sample_valid = 1'b1;
        arm_cfg(100, 1'b1, 5);
        sample_valid = 1'b0;
        check("rearm_state", int'(state_o), 1);
        check("rearm_done", int'(capture_done), 0);
        run_done(0, 0, 2000, n);
        check("rearm_nsamp", n, 607);
        rd("rearm_r5", 5, 100);
        rd("rearm_r0", 0, 95);
        rd_window("rearm_win");

        // Reset mid-capture
        arm_cfg(0, 1'b1, 50);
        send(1);
        send(2);
        send(3);
        rst = 1'b0;
        tick();
        check("mrst_state", int'(state_o), 0);
        check("mrst_done", int'(capture_done), 0);
        check("mrst_rd", int'($signed(rd_data)), 0);
        rst = 1'b1;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
